// File: rtl/data_mem_responder.sv
// Multi-cycle word-addressed data memory that answers one load/store at a time
// after a fixed number of wait states, with separate request and response handshakes.
module data_mem_responder #(
  parameter int          ADDR_BITS   = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbgState
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // responder never withdraws resp_valid or changes rdata/err until it is taken.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateE;

  localparam int          DEPTH = 1 << ADDR_BITS;
  localparam logic [32:0] SPAN  = 33'(4) << ADDR_BITS;

  stateE stateQ, stateD;
  logic [3:0]  cntQ;
  logic        startedQ;
  logic        writeQ;
  logic [31:0] addrQ, wdataQ;
  logic [31:0] rdataQ;
  logic        errQ;
  logic [31:0] mem [DEPTH];

  logic        accept, commit;
  logic        cWrite;
  logic [31:0] cAddr, cWdata, offset;
  logic        addrErr;
  logic [ADDR_BITS-1:0] idx;

  assign req_ready  = startedQ && (stateQ == IDLE);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (stateQ == RESP);
  assign resp_rdata = rdataQ;
  assign resp_err   = errQ;
  assign dbgState   = stateQ;

  // With no wait states the commit happens on the accept edge itself, so the
  // live request fields are used instead of the captured ones.
  assign cWrite = (stateQ == IDLE) ? req_write : writeQ;
  assign cAddr  = (stateQ == IDLE) ? req_addr  : addrQ;
  assign cWdata = (stateQ == IDLE) ? req_wdata : wdataQ;

  assign offset  = cAddr - BASE_ADDR;
  assign addrErr = (cAddr[1:0] != 2'b00) || (cAddr < BASE_ADDR) || ({1'b0, offset} >= SPAN);
  assign idx     = ADDR_BITS'(offset >> 2);
  assign commit  = (stateD == RESP) && (stateQ != RESP);

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: if (accept) stateD = (WAIT_CYCLES > 0) ? WAIT : RESP;
      WAIT: if (cntQ == 4'd0) stateD = RESP;
      RESP: if (resp_ready) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ   <= IDLE;
      startedQ <= 1'b0;
      cntQ     <= 4'd0;
      writeQ   <= 1'b0;
      addrQ    <= 32'd0;
      wdataQ   <= 32'd0;
      rdataQ   <= 32'd0;
      errQ     <= 1'b0;
    end else begin
      stateQ   <= stateD;
      startedQ <= 1'b1;
      if (accept) begin
        writeQ <= req_write;
        addrQ  <= req_addr;
        wdataQ <= req_wdata;
      end
      if ((stateQ == IDLE) && (stateD == WAIT)) cntQ <= 4'(WAIT_CYCLES - 1);
      else if ((stateQ == WAIT) && (cntQ != 4'd0)) cntQ <= cntQ - 4'd1;
      if (commit) begin
        errQ   <= addrErr;
        rdataQ <= (!cWrite && !addrErr) ? mem[idx] : 32'd0;
      end else if ((stateQ == RESP) && resp_ready) begin
        errQ   <= 1'b0;
        rdataQ <= 32'd0;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (commit && cWrite && !addrErr) mem[idx] <= cWdata;
  end

endmodule
